fpu_trig_reduce_arbiter: RTL and testbench
==========================================

FPU_TRIG_REDUCE_ARBITER -- requirements
Module: fpu_trig_reduce_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 512: maximum RUN cycles before abort.
REQ-002 Parameter BYPASS_EXP, default 16'h3FFE: biased exponents below this bypass reduction.
REQ-003 Parameter OOR_EXP, default 16'h403E: biased exponents at or above this are out of range (|x| >= 2^63).
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 req_valid  in  2  request valid per requester (bit0 = transcendental microsequencer, bit1 = FPREM1 path).
REQ-007 req_angle0 / req_angle1  in  80  extended-real angle per requester.
REQ-008 req_ready  out  2  one-hot grant/accept pulse.
REQ-009 rsp_valid  out  1; rsp_ready  in  1  response handshake.
REQ-010 rsp_id  out  1  index of the requester being served.
REQ-011 rsp_angle  out  80  reduced magnitude, sign bit 0.
REQ-012 rsp_quadrant  out  2; rsp_neg  out  1  sign of the original input.
REQ-013 rsp_status  out  2  00 ok, 01 out-of-range (C2), 10 invalid (NaN/Inf), 11 timeout/engine error.
REQ-014 ph_enable  out  1; ph_angle_in  out  80  level-held launch to the shared Payne-Hanek engine.
REQ-015 ph_angle_out  in  80; ph_quadrant  in  2; ph_done  in  1; ph_error  in  1  engine results.
REQ-016 busy  out  1  high in every state except IDLE.

Function
REQ-017 States: IDLE, CLASSIFY, RUN, DRAIN, RESP.
REQ-018 IDLE: if any req_valid, grant round-robin via a last-grant pointer, pulse req_ready for exactly one cycle on the granted bit, capture the angle and the id, and go to CLASSIFY.
REQ-019 Simultaneous requests: grant the requester not granted last; the pointer resets to 1 so that req0 wins the first tie.
REQ-020 CLASSIFY (1 cycle), evaluated in this priority order: exponent 7FFF -> status 10; exponent >= OOR_EXP -> status 01; exponent < BYPASS_EXP (includes zero and denormals) -> status 00, quadrant 0, angle = |x|; otherwise go to RUN.
REQ-021 The first three CLASSIFY outcomes go directly to RESP, never assert ph_enable, and set rsp_angle = |input|.
REQ-022 RUN: ph_angle_in = |x| is held stable, ph_enable is held high, and a cycle counter starts at 0.
REQ-023 RUN, ph_done & !ph_error: capture ph_angle_out and ph_quadrant, status 00, go to DRAIN.
REQ-024 RUN, ph_done & ph_error: status 11, rsp_angle = |input|, go to DRAIN.
REQ-025 RUN, counter reaches TIMEOUT_CYCLES-1 without ph_done: status 11, rsp_angle = |input|, go to DRAIN.
REQ-026 ph_enable drops on the transition out of RUN and stays low in DRAIN (1 cycle), RESP and IDLE, giving the engine at least 2 low cycles between launches.
REQ-027 RESP: rsp_valid = 1, rsp_neg = input sign; all rsp_* outputs are stable while rsp_valid & !rsp_ready.
REQ-028 rsp_valid & rsp_ready: go to IDLE, where a new grant is possible on the next cycle.
REQ-029 Bypass latency: rsp_valid is asserted 2 cycles after the req_ready pulse.
REQ-030 Engine latency: rsp_valid is asserted 2 cycles after ph_done is sampled.
REQ-031 req_valid withdrawn after grant is ignored; the captured request completes.
REQ-032 ph_done seen outside RUN is ignored.

Reset
REQ-033 reset low forces asynchronously: state IDLE; ph_enable, rsp_valid, req_ready, busy = 0; rsp_* and ph_angle_in = 0; pointer = 1; counter = 0.
REQ-034 Reset asserted mid-RUN drops ph_enable immediately and discards the in-flight request; no response is produced for it.

Verification
REQ-035 Bypass: req0 angle 0x3FFD_8000000000000000 (0.25) -> rsp_angle identical, quadrant 0, status 00, rsp_valid 2 cycles after req_ready, ph_enable never asserted.
REQ-036 Engine: req0 = 0x4001_C90FDAA22168C235 (2π); engine model returns done after 20 cycles with quadrant 0 -> ph_enable high for exactly those 20 cycles, response carries the model outputs, status 00; negative input 0xC001_... -> rsp_neg = 1 and ph_angle_in has sign 0.
REQ-037 Specials: 0x403E_8000000000000000 -> status 01, no launch; 0x7FFF_C000000000000000 -> status 10, no launch.
REQ-038 Arbitration: both requesters held valid from reset -> grants req0, req1, req0, req1 in order.
REQ-039 Timeout/error: engine model never signals done -> status 11 after 512 RUN cycles; ph_done with ph_error -> status 11; reset pulsed mid-RUN -> ph_enable low before the next clock edge and no response produced.
REQ-040 Backpressure: rsp_ready held low for 5 cycles -> rsp_* outputs stable, no new req_ready pulse until the response is accepted.

Source files
------------

// File: rtl/fpu_trig_reduce_arbiter.sv
`timescale 1ns / 1ps
`default_nettype none
// ----------------------------------------------------------------------------
// fpu_trig_reduce_arbiter - 2-way round-robin classifier/launcher for the shared
// Payne-Hanek argument-reduction engine (x87 80-bit extended reals). Rev 1.0
// ----------------------------------------------------------------------------
module fpu_trig_reduce_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 512,
  parameter logic [15:0] BYPASS_EXP     = 16'h3FFE,
  parameter logic [15:0] OOR_EXP        = 16'h403E
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  i_req_valid,
  input  logic [79:0] i_req_angle0,
  input  logic [79:0] i_req_angle1,
  output logic [1:0]  o_req_ready,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic        o_rsp_id,
  output logic [79:0] o_rsp_angle,
  output logic [1:0]  o_rsp_quadrant,
  output logic        o_rsp_neg,
  output logic [1:0]  o_rsp_status,
  output logic        o_ph_enable,
  output logic [79:0] o_ph_angle_in,
  input  logic [79:0] i_ph_angle_out,
  input  logic [1:0]  i_ph_quadrant,
  input  logic        i_ph_done,
  input  logic        i_ph_error,
  output logic        o_busy
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] c_STS_OK  = 2'b00;
  localparam logic [1:0] c_STS_OOR = 2'b01;
  localparam logic [1:0] c_STS_INV = 2'b10;
  localparam logic [1:0] c_STS_ERR = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CLASSIFY = 3'd1,
    S_RUN      = 3'd2,
    S_DRAIN    = 3'd3,
    S_RESP     = 3'd4
  } state_t;

  state_t            r_state;
  logic              r_last;
  logic [79:0]       r_angle;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_rsp_valid;
  logic              r_rsp_id;
  logic [79:0]       r_rsp_angle;
  logic [1:0]        r_rsp_quadrant;
  logic              r_rsp_neg;
  logic [1:0]        r_rsp_status;
  logic              r_ph_enable;
  logic [79:0]       r_ph_angle_in;

  logic [1:0]        w_grant;
  logic [79:0]       w_sel_angle;
  logic [15:0]       w_exp;
  logic [79:0]       w_abs;

  // On a tie the requester not served last wins; a lone requester always wins.
  always_comb begin
    w_grant = i_req_valid;
    if (i_req_valid == 2'b11) begin
      w_grant = r_last ? 2'b01 : 2'b10;
    end
  end

  assign w_sel_angle = w_grant[1] ? i_req_angle1 : i_req_angle0;
  assign w_exp       = {1'b0, r_angle[78:64]};
  assign w_abs       = {1'b0, r_angle[78:0]};

  // Grant decode is gated by reset so no accept pulse leaks out while held in reset.
  assign o_req_ready = ((r_state == S_IDLE) && reset) ? w_grant : 2'b00;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_last         <= 1'b1;
      r_angle        <= '0;
      r_cnt          <= '0;
      r_rsp_valid    <= 1'b0;
      r_rsp_id       <= 1'b0;
      r_rsp_angle    <= '0;
      r_rsp_quadrant <= 2'b00;
      r_rsp_neg      <= 1'b0;
      r_rsp_status   <= c_STS_OK;
      r_ph_enable    <= 1'b0;
      r_ph_angle_in  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|i_req_valid) begin
            r_angle  <= w_sel_angle;
            r_rsp_id <= w_grant[1];
            r_last   <= w_grant[1];
            r_state  <= S_CLASSIFY;
          end
        end

        S_CLASSIFY: begin
          r_rsp_neg <= r_angle[79];
          if (w_exp == 16'h7FFF) begin
            r_rsp_status   <= c_STS_INV;
            r_rsp_angle    <= w_abs;
            r_rsp_quadrant <= 2'b00;
            r_rsp_valid    <= 1'b1;
            r_state        <= S_RESP;
          end else if (w_exp >= OOR_EXP) begin
            r_rsp_status   <= c_STS_OOR;
            r_rsp_angle    <= w_abs;
            r_rsp_quadrant <= 2'b00;
            r_rsp_valid    <= 1'b1;
            r_state        <= S_RESP;
          end else if (w_exp < BYPASS_EXP) begin
            // |x| < 0.5 is already reduced: zero, denormals and small normals
            r_rsp_status   <= c_STS_OK;
            r_rsp_angle    <= w_abs;
            r_rsp_quadrant <= 2'b00;
            r_rsp_valid    <= 1'b1;
            r_state        <= S_RESP;
          end else begin
            r_ph_angle_in  <= w_abs;
            r_ph_enable    <= 1'b1;
            r_cnt          <= '0;
            r_state        <= S_RUN;
          end
        end

        S_RUN: begin
          if (i_ph_done) begin
            r_ph_enable <= 1'b0;
            r_state     <= S_DRAIN;
            if (i_ph_error) begin
              r_rsp_status   <= c_STS_ERR;
              r_rsp_angle    <= w_abs;
              r_rsp_quadrant <= 2'b00;
            end else begin
              r_rsp_status   <= c_STS_OK;
              r_rsp_angle    <= i_ph_angle_out;
              r_rsp_quadrant <= i_ph_quadrant;
            end
          end else if (r_cnt == c_CNT_LAST) begin
            r_ph_enable    <= 1'b0;
            r_rsp_status   <= c_STS_ERR;
            r_rsp_angle    <= w_abs;
            r_rsp_quadrant <= 2'b00;
            r_state        <= S_DRAIN;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_DRAIN: begin
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end

        S_RESP: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_ph_enable <= 1'b0;
          r_rsp_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign o_rsp_valid    = r_rsp_valid;
  assign o_rsp_id       = r_rsp_id;
  assign o_rsp_angle    = r_rsp_angle;
  assign o_rsp_quadrant = r_rsp_quadrant;
  assign o_rsp_neg      = r_rsp_neg;
  assign o_rsp_status   = r_rsp_status;
  assign o_ph_enable    = r_ph_enable;
  assign o_ph_angle_in  = r_ph_angle_in;
  assign o_busy         = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_fpu_trig_reduce_arbiter.sv
`timescale 1ns / 1ps
`default_nettype none
// ----------------------------------------------------------------------------
// tb_fpu_trig_reduce_arbiter - directed vector bench with a behavioural engine
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_fpu_trig_reduce_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [79:0] req_angle0, req_angle1;
  logic [1:0]  req_ready;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_neg;
  logic [79:0] rsp_angle;
  logic [1:0]  rsp_quadrant, rsp_status;
  logic        ph_enable, busy;
  logic [79:0] ph_angle_in;
  logic [79:0] ph_angle_out = '0;
  logic [1:0]  ph_quadrant  = 2'b00;
  logic        ph_error     = 1'b0;
  logic        ph_done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  fpu_trig_reduce_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .i_req_valid    (req_valid),
    .i_req_angle0   (req_angle0),
    .i_req_angle1   (req_angle1),
    .o_req_ready    (req_ready),
    .o_rsp_valid    (rsp_valid),
    .i_rsp_ready    (rsp_ready),
    .o_rsp_id       (rsp_id),
    .o_rsp_angle    (rsp_angle),
    .o_rsp_quadrant (rsp_quadrant),
    .o_rsp_neg      (rsp_neg),
    .o_rsp_status   (rsp_status),
    .o_ph_enable    (ph_enable),
    .o_ph_angle_in  (ph_angle_in),
    .i_ph_angle_out (ph_angle_out),
    .i_ph_quadrant  (ph_quadrant),
    .i_ph_done      (ph_done),
    .i_ph_error     (ph_error),
    .o_busy         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Engine model: raises done on the m_delay-th enabled cycle (never if 0).
  int          m_delay = 0;
  logic        m_err   = 1'b0;
  logic [1:0]  m_quad  = 2'b00;
  logic [79:0] m_out   = '0;
  logic        m_done  = 1'b0;
  logic        f_done  = 1'b0;
  int          en_cnt  = 0;
  int          en_total = 0;
  int          done_cyc = 0;
  logic [79:0] ph_seen = '0;
  logic        ph_unstable = 1'b0;

  assign ph_done = m_done | f_done;

  always @(negedge clk) begin
    if (ph_enable) begin
      if (en_cnt == 0) ph_seen = ph_angle_in;
      else if (ph_angle_in != ph_seen) ph_unstable = 1'b1;
      en_cnt++;
      en_total++;
      if (m_delay != 0 && en_cnt == m_delay) begin
        m_done       = 1'b1;
        done_cyc     = cyc;
        ph_error     = m_err;
        ph_quadrant  = m_quad;
        ph_angle_out = m_out;
      end else begin
        m_done = 1'b0;
      end
    end else begin
      en_cnt = 0;
      m_done = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        id;
    logic [79:0] angle;
    int          delay;
    logic        err;
    logic [1:0]  quad;
    logic [79:0] out;
    logic [1:0]  status;
    logic [79:0] exp_angle;
    logic [1:0]  exp_quad;
    logic        chk_quad;
    logic        exp_neg;
    int          exp_en;
  } vec_t;

  vec_t        vt[14];
  logic        got;
  int          rdy_cyc;
  logic [1:0]  grants[4];
  int          ng;
  logic        seen_rsp;

  initial begin
    //        id    angle                        dly err  q    engine out                   sts    exp angle                   eq  cq  neg  en
    vt[0]  = '{1'b0, 80'h3FFD_8000000000000000, 0,  1'b0, 2'd0, 80'h0,                       2'b00, 80'h3FFD_8000000000000000, 2'd0, 1'b1, 1'b0, 0};
    vt[1]  = '{1'b1, 80'hBFFD_8000000000000000, 0,  1'b0, 2'd0, 80'h0,                       2'b00, 80'h3FFD_8000000000000000, 2'd0, 1'b1, 1'b1, 0};
    vt[2]  = '{1'b0, 80'h0000_0000000000000000, 0,  1'b0, 2'd0, 80'h0,                       2'b00, 80'h0000_0000000000000000, 2'd0, 1'b1, 1'b0, 0};
    vt[3]  = '{1'b1, 80'h8000_0000000000000001, 0,  1'b0, 2'd0, 80'h0,                       2'b00, 80'h0000_0000000000000001, 2'd0, 1'b1, 1'b1, 0};
    vt[4]  = '{1'b0, 80'h3FFE_C90FDAA22168C235, 5,  1'b0, 2'd1, 80'h3FFE_8000000000000000,   2'b00, 80'h3FFE_8000000000000000, 2'd1, 1'b1, 1'b0, 5};
    vt[5]  = '{1'b0, 80'h4001_C90FDAA22168C235, 20, 1'b0, 2'd0, 80'h3FBE_8000000000000000,   2'b00, 80'h3FBE_8000000000000000, 2'd0, 1'b1, 1'b0, 20};
    vt[6]  = '{1'b1, 80'hC001_C90FDAA22168C235, 20, 1'b0, 2'd2, 80'h3FFC_A000000000000000,   2'b00, 80'h3FFC_A000000000000000, 2'd2, 1'b1, 1'b1, 20};
    vt[7]  = '{1'b0, 80'h403E_8000000000000000, 0,  1'b0, 2'd0, 80'h0,                       2'b01, 80'h403E_8000000000000000, 2'd0, 1'b0, 1'b0, 0};
    vt[8]  = '{1'b1, 80'hC03E_8000000000000000, 0,  1'b0, 2'd0, 80'h0,                       2'b01, 80'h403E_8000000000000000, 2'd0, 1'b0, 1'b1, 0};
    vt[9]  = '{1'b0, 80'h403D_FFFFFFFFFFFFFFFF, 3,  1'b0, 2'd3, 80'h3FFF_C000000000000000,   2'b00, 80'h3FFF_C000000000000000, 2'd3, 1'b1, 1'b0, 3};
    vt[10] = '{1'b1, 80'h7FFF_C000000000000000, 0,  1'b0, 2'd0, 80'h0,                       2'b10, 80'h7FFF_C000000000000000, 2'd0, 1'b0, 1'b0, 0};
    vt[11] = '{1'b0, 80'hFFFF_8000000000000000, 0,  1'b0, 2'd0, 80'h0,                       2'b10, 80'h7FFF_8000000000000000, 2'd0, 1'b0, 1'b1, 0};
    vt[12] = '{1'b1, 80'h4005_A000000000000000, 7,  1'b1, 2'd2, 80'h1234,                    2'b11, 80'h4005_A000000000000000, 2'd0, 1'b0, 1'b0, 7};
    vt[13] = '{1'b0, 80'hC002_8000000000000000, 0,  1'b0, 2'd0, 80'h0,                       2'b11, 80'h4002_8000000000000000, 2'd0, 1'b0, 1'b1, 512};

    // Reset state, with both requesters already asserting valid.
    reset      = 1'b0;
    rsp_ready  = 1'b1;
    req_valid  = 2'b11;
    req_angle0 = 80'h3FFD_8000000000000000;
    req_angle1 = 80'h3FFC_8000000000000000;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_ph_enable", ph_enable, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rsp_angle", rsp_angle, 80'h0);
    chk("rst_ph_angle_in", ph_angle_in, 80'h0);
    chk("rst_rsp_status", rsp_status, 2'b00);

    // Arbitration: both held valid from reset must alternate, req0 first.
    @(posedge clk); #1 reset = 1'b1;
    ng = 0;
    for (int t = 0; t < 40 && ng < 4; t++) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin
        grants[ng] = req_ready;
        ng++;
      end
    end
    chk("arb_grant_count", ng, 4);
    chk("arb_grant0", grants[0], 2'b01);
    chk("arb_grant1", grants[1], 2'b10);
    chk("arb_grant2", grants[2], 2'b01);
    chk("arb_grant3", grants[3], 2'b10);
    @(posedge clk); #1 req_valid = 2'b00;
    repeat (6) @(posedge clk);

    // Table-driven single requests.
    for (int i = 0; i < 14; i++) begin
      m_delay = vt[i].delay;
      m_err   = vt[i].err;
      m_quad  = vt[i].quad;
      m_out   = vt[i].out;
      @(posedge clk); #1;
      en_total    = 0;
      ph_unstable = 1'b0;
      ph_seen     = '0;
      if (vt[i].id) req_angle1 = vt[i].angle;
      else          req_angle0 = vt[i].angle;
      req_valid = vt[i].id ? 2'b10 : 2'b01;
      got = 1'b0;
      for (int t = 0; t < 10 && !got; t++) begin
        @(negedge clk);
        if (req_ready != 2'b00) got = 1'b1;
      end
      chk($sformatf("v%0d_grant", i), req_ready, vt[i].id ? 2'b10 : 2'b01);
      rdy_cyc = cyc;
      @(posedge clk); #1;
      req_valid  = 2'b00;
      req_angle0 = '1;
      req_angle1 = '1;
      got = 1'b0;
      for (int t = 0; t < 700 && !got; t++) begin
        @(negedge clk);
        if (rsp_valid) got = 1'b1;
      end
      chk($sformatf("v%0d_rsp_valid", i), got, 1'b1);
      if (got) begin
        chk($sformatf("v%0d_id", i), rsp_id, vt[i].id);
        chk($sformatf("v%0d_status", i), rsp_status, vt[i].status);
        chk($sformatf("v%0d_angle", i), rsp_angle, vt[i].exp_angle);
        chk($sformatf("v%0d_neg", i), rsp_neg, vt[i].exp_neg);
        if (vt[i].chk_quad) chk($sformatf("v%0d_quad", i), rsp_quadrant, vt[i].exp_quad);
        chk($sformatf("v%0d_enable_cycles", i), en_total, vt[i].exp_en);
        if (vt[i].exp_en == 0) begin
          chk($sformatf("v%0d_bypass_latency", i), cyc - rdy_cyc, 2);
        end else begin
          if (vt[i].delay != 0) chk($sformatf("v%0d_engine_latency", i), cyc - done_cyc, 2);
          chk($sformatf("v%0d_ph_angle_in", i), ph_seen, {1'b0, vt[i].angle[78:0]});
          chk($sformatf("v%0d_ph_unstable", i), ph_unstable, 1'b0);
        end
      end
    end
    m_delay = 0;
    m_err   = 1'b0;

    // Backpressure: response held, second requester waits until acceptance.
    @(posedge clk); #1;
    rsp_ready  = 1'b0;
    req_angle0 = 80'h3FFD_8000000000000000;
    req_valid  = 2'b01;
    got = 1'b0;
    for (int t = 0; t < 10 && !got; t++) begin
      @(negedge clk);
      if (req_ready != 2'b00) got = 1'b1;
    end
    chk("bp_grant", req_ready, 2'b01);
    @(posedge clk); #1;
    req_angle1 = 80'h3FFC_C000000000000000;
    req_valid  = 2'b10;
    got = 1'b0;
    for (int t = 0; t < 10 && !got; t++) begin
      @(negedge clk);
      if (rsp_valid) got = 1'b1;
    end
    chk("bp_rsp_valid", got, 1'b1);
    for (int t = 0; t < 5; t++) begin
      if (t != 0) @(negedge clk);
      chk("bp_hold_valid", rsp_valid, 1'b1);
      chk("bp_hold_angle", rsp_angle, 80'h3FFD_8000000000000000);
      chk("bp_hold_status_id", {rsp_status, rsp_quadrant, rsp_id, rsp_neg}, 6'b000000);
      chk("bp_no_grant", req_ready, 2'b00);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 5 && !got; t++) begin
      @(negedge clk);
      if (req_ready != 2'b00) got = 1'b1;
    end
    chk("bp_next_grant", req_ready, 2'b10);
    @(posedge clk); #1 req_valid = 2'b00;
    got = 1'b0;
    for (int t = 0; t < 10 && !got; t++) begin
      @(negedge clk);
      if (rsp_valid) got = 1'b1;
    end
    chk("bp_second_rsp", rsp_angle, 80'h3FFC_C000000000000000);

    // ph_done while idle must not start anything.
    @(posedge clk); #1 f_done = 1'b1;
    @(posedge clk); #1 f_done = 1'b0;
    @(negedge clk);
    chk("idle_done_busy", busy, 1'b0);
    chk("idle_done_rsp", rsp_valid, 1'b0);

    // Reset in the middle of RUN: enable drops at once, request is lost.
    @(posedge clk); #1;
    req_angle0 = 80'h4001_C90FDAA22168C235;
    req_valid  = 2'b01;
    @(posedge clk); #1 req_valid = 2'b00;
    got = 1'b0;
    for (int t = 0; t < 10 && !got; t++) begin
      @(negedge clk);
      if (ph_enable) got = 1'b1;
    end
    chk("rr_launch", ph_enable, 1'b1);
    repeat (10) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("rr_enable_drop", ph_enable, 1'b0);
    chk("rr_busy_drop", busy, 1'b0);
    @(posedge clk); #1 reset = 1'b1;
    seen_rsp = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (rsp_valid || ph_enable) seen_rsp = 1'b1;
    end
    chk("rr_no_response", seen_rsp, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
